// File: rtl/rsp_rx.sv
// SD CMD-line response receiver: waits for a start bit, deserializes a 48- or 136-bit
// frame on SD-clock enables, checks CRC7 and the end bit, and presents the payload.
module rsp_rx (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clk_en_i,
    input  logic         cmd_i,
    input  logic         long_rsp_i,
    input  logic         start_listening_i,
    output logic         receiving_o,
    output logic         rsp_valid_o,
    output logic         end_bit_err_o,
    output logic         crc_corr_o,
    output logic [119:0] rsp_o
);

    // state      | meaning
    // IDLE       | not armed, outputs hold the last frame
    // WAIT_START | armed, CMD idle high, waiting for a 0 start bit
    // RX         | shifting frame bits, counter = frame bit index
    // DONE       | frame complete, rsp_valid_o high until next enable
    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RX,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic           long_q, long_d;
    logic [119:0]   rsp_q, rsp_d;
    logic [6:0]     crc_q, crc_d;
    logic [6:0]     rx_crc_q, rx_crc_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           end_err_q, end_err_d;
    logic           crc_ok_q, crc_ok_d;

    // Serial CRC7, generator x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    always_comb begin
        state_d   = state_q;
        long_d    = long_q;
        rsp_d     = rsp_q;
        crc_d     = crc_q;
        rx_crc_d  = rx_crc_q;
        cnt_d     = cnt_q;
        end_err_d = end_err_q;
        crc_ok_d  = crc_ok_q;

        case (state_q)
            IDLE, DONE: begin
                if (clk_en_i) begin
                    state_d = IDLE;
                    if (start_listening_i) begin
                        state_d   = WAIT_START;
                        long_d    = long_rsp_i;
                        rsp_d     = '0;
                        crc_d     = '0;
                        rx_crc_d  = '0;
                        cnt_d     = '0;
                        end_err_d = 1'b0;
                        crc_ok_d  = 1'b0;
                    end
                end
            end
            WAIT_START: begin
                if (clk_en_i && !cmd_i) begin
                    state_d = RX;
                    if (long_q) begin
                        cnt_d = 8'd134;
                    end else begin
                        cnt_d = 8'd46;
                        rsp_d = {rsp_q[118:0], cmd_i};
                        crc_d = crc7_step(crc_q, cmd_i);
                    end
                end
            end
            RX: begin
                if (clk_en_i) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q > 8'd7) begin
                        // Long-frame transmission/reserved bits (134..128) are simply dropped.
                        if (!long_q || cnt_q < 8'd128) begin
                            rsp_d = {rsp_q[118:0], cmd_i};
                            crc_d = crc7_step(crc_q, cmd_i);
                        end
                    end else if (cnt_q != 8'd0) begin
                        rx_crc_d = {rx_crc_q[5:0], cmd_i};
                    end else begin
                        end_err_d = ~cmd_i;
                        crc_ok_d  = (rx_crc_q == crc_q);
                        cnt_d     = '0;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            long_q    <= 1'b0;
            rsp_q     <= '0;
            crc_q     <= '0;
            rx_crc_q  <= '0;
            cnt_q     <= '0;
            end_err_q <= 1'b0;
            crc_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            long_q    <= long_d;
            rsp_q     <= rsp_d;
            crc_q     <= crc_d;
            rx_crc_q  <= rx_crc_d;
            cnt_q     <= cnt_d;
            end_err_q <= end_err_d;
            crc_ok_q  <= crc_ok_d;
        end
    end

    assign receiving_o   = (state_q == RX);
    assign rsp_valid_o   = (state_q == DONE);
    assign end_bit_err_o = end_err_q;
    assign crc_corr_o    = crc_ok_q;
    assign rsp_o         = rsp_q;

endmodule

// File: tb/tb_rsp_rx.sv
// Bench for rsp_rx: directed vector table, hand-written corner sequences, and random
// frames checked against a frame-level reference (CRC by polynomial long division).
module tb_rsp_rx;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         clk_en_i;
    logic         cmd_i;
    logic         long_rsp_i;
    logic         start_listening_i;
    logic         receiving_o;
    logic         rsp_valid_o;
    logic         end_bit_err_o;
    logic         crc_corr_o;
    logic [119:0] rsp_o;

    int checks   = 0;
    int failures = 0;
    int en_div   = 1;

    rsp_rx dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .clk_en_i          (clk_en_i),
        .cmd_i             (cmd_i),
        .long_rsp_i        (long_rsp_i),
        .start_listening_i (start_listening_i),
        .receiving_o       (receiving_o),
        .rsp_valid_o       (rsp_valid_o),
        .end_bit_err_o     (end_bit_err_o),
        .crc_corr_o        (crc_corr_o),
        .rsp_o             (rsp_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         lg;
        logic [135:0] fr;
        int           div;
        logic [119:0] rsp;
        logic         crc;
        logic         eb;
    } vec_t;

    task automatic check(input string nm, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Remainder of M(x)*x^7 mod (x^7+x^3+1) over the CRC-covered frame bits.
    function automatic logic [6:0] ref_crc(input logic [135:0] fr, input logic lg);
        logic [7:0] r;
        int hi;
        r  = '0;
        hi = lg ? 127 : 47;
        for (int i = hi; i >= 1; i--) begin
            r = {r[6:0], (i >= 8) ? fr[i] : 1'b0};
            if (r[7]) r = r ^ 8'h89;
        end
        return r[6:0];
    endfunction

    // One SD-clock period: en_div system cycles, enable on the last; noise elsewhere.
    task automatic tick(input logic b, input logic sl, input logic lg, output int vcnt);
        vcnt = 0;
        for (int k = 0; k < en_div; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o) vcnt++;
            if (k == en_div - 1) begin
                clk_en_i          = 1'b1;
                cmd_i             = b;
                start_listening_i = sl;
                long_rsp_i        = lg;
            end else begin
                clk_en_i          = 1'b0;
                cmd_i             = 1'($urandom_range(0, 1));
                start_listening_i = 1'($urandom_range(0, 1));
                long_rsp_i        = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [135:0] fr, input logic lg, input int pre,
                              input logic do_arm, input int sl_at, input logic rearm,
                              input logic next_lg, input logic [119:0] e_rsp,
                              input logic e_crc, input logic e_end);
        int n, valid_at, vc, extra;
        n = lg ? 136 : 48;
        if (do_arm) tick(1'b1, 1'b1, lg, vc);
        for (int p = 0; p < pre; p++) tick(1'b1, 1'b0, ~lg, vc);
        valid_at = 0;
        for (int i = 1; i <= n; i++) begin
            tick(fr[n-i], (i == sl_at), ~lg, vc);
            if (i == 1) check("receiving_rise", 136'(receiving_o), 136'(1));
            if (rsp_valid_o && valid_at == 0) valid_at = i;
        end
        extra = 0;
        while (valid_at == 0 && extra < 40) begin
            tick(1'b1, 1'b0, lg, vc);
            extra++;
            if (rsp_valid_o) valid_at = n + extra;
        end
        check("valid_latency", 136'(valid_at), 136'(n));
        check("receiving_fall", 136'(receiving_o), 136'(0));
        check("rsp", 136'(rsp_o), 136'(e_rsp));
        check("crc_corr", 136'(crc_corr_o), 136'(e_crc));
        check("end_bit_err", 136'(end_bit_err_o), 136'(e_end));
        tick(1'b1, rearm, next_lg, vc);
        check("valid_width", 136'(vc), 136'(en_div));
        check("valid_drop", 136'(rsp_valid_o), 136'(0));
        if (!rearm) check("rsp_hold", 136'(rsp_o), 136'(e_rsp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp"}, 136'(rsp_o), 136'(0));
        check({tag, "_receiving"}, 136'(receiving_o), 136'(0));
        check({tag, "_valid"}, 136'(rsp_valid_o), 136'(0));
        check({tag, "_end_err"}, 136'(end_bit_err_o), 136'(0));
        check({tag, "_crc_corr"}, 136'(crc_corr_o), 136'(0));
    endtask

    vec_t vecs[5];

    initial begin
        logic [135:0] fr;
        logic [119:0] e_rsp;
        logic [6:0]   crc;
        logic         lg;
        int           vc;

        vecs[0] = '{1'b0, 136'h48000001AA87, 1, 120'h48000001AA, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 136'h48000001AA86, 1, 120'h48000001AA, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 136'h48000001AA85, 1, 120'h48000001AA, 1'b0, 1'b0};
        vecs[3] = '{1'b1, {8'h3F, 120'h0, 8'h01}, 1, 120'h0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 136'h48000001AA87, 4, 120'h48000001AA, 1'b1, 1'b0};

        rst_i = 1'b1; clk_en_i = 1'b1; cmd_i = 1'b1;
        long_rsp_i = 1'b0; start_listening_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0; start_listening_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            en_div = vecs[i].div;
            send_frame(vecs[i].fr, vecs[i].lg, 2, 1'b1, 0, 1'b0, 1'b0,
                       vecs[i].rsp, vecs[i].crc, vecs[i].eb);
            if (i == 0) check("index_field", 136'(rsp_o[37:32]), 136'(8));
        end

        // Reset in the middle of a frame, then an unarmed start bit must be ignored.
        en_div = 1;
        tick(1'b1, 1'b1, 1'b0, vc);
        for (int i = 1; i <= 20; i++) tick(vecs[0].fr[48-i], 1'b0, 1'b0, vc);
        check("mid_rx_receiving", 136'(receiving_o), 136'(1));
        @(negedge clk_i);
        rst_i = 1'b1; clk_en_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_all_zero("mid_rx_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        tick(1'b0, 1'b0, 1'b0, vc);
        tick(1'b0, 1'b0, 1'b0, vc);
        check("idle_after_reset", 136'(receiving_o), 136'(0));

        // Re-arm with a start_listening pulse mid-frame, then back-to-back via DONE.
        send_frame(vecs[0].fr, 1'b0, 1, 1'b1, 10, 1'b1, 1'b1,
                   vecs[0].rsp, 1'b1, 1'b0);
        send_frame(vecs[3].fr, 1'b1, 0, 1'b0, 30, 1'b0, 1'b0,
                   vecs[3].rsp, 1'b1, 1'b0);

        for (int t = 0; t < 16; t++) begin
            en_div = $urandom_range(1, 3);
            lg = ($urandom_range(0, 3) == 0);
            fr = '0;
            for (int w = 0; w < 4; w++) fr[w*32 +: 32] = $urandom();
            fr[135:128] = 8'($urandom());
            if (lg) begin
                fr[135] = 1'b0;
            end else begin
                fr[135:48] = '0;
                fr[47] = 1'b0;
            end
            crc = ref_crc(fr, lg);
            if ($urandom_range(0, 3) == 0) crc = crc ^ 7'(1 << $urandom_range(0, 6));
            fr[7:1] = crc;
            fr[0] = ($urandom_range(0, 3) != 0);
            e_rsp = lg ? fr[127:8] : {80'h0, fr[47:8]};
            send_frame(fr, lg, $urandom_range(0, 3), 1'b1, 0, 1'b0, 1'b0,
                       e_rsp, (fr[7:1] == ref_crc(fr, lg)), ~fr[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
